// File: rtl/pipeifq.sv
// pipeifq: instruction prefetch queue between fetch and decode.
// Circular buffer of DEPTH {pc4, instruction} pairs. The head entry is
// presented combinationally to decode; a redirect (flush) empties the queue.
// Also counts decode cycles lost to an empty queue, saturating at 16'hFFFF.
module pipeifq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_valid,
    input  logic [31:0]   f_pc4,
    input  logic [31:0]   f_ins,
    output logic          f_ready,
    input  logic          wpcir,
    input  logic          flush,
    output logic          d_valid,
    output logic [31:0]   dpc4,
    output logic [31:0]   inst,
    output logic [AW:0]   count,
    output logic [15:0]   bubble_cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [63:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [15:0]   r_bubble;

    logic w_push;
    logic w_pop;
    logic w_empty;

    // Full/empty come from the registered count only, so f_ready never
    // depends on a same-cycle pop.
    assign w_empty = (r_count == '0);
    assign f_ready = (r_count != FULL);
    assign d_valid = ~w_empty;
    assign w_push  = f_valid & f_ready & ~flush;
    assign w_pop   = d_valid & wpcir & ~flush;

    // Head entry, forced to zero (nop, pc4=0) when the queue is empty.
    assign dpc4       = d_valid ? r_mem[r_rp][63:32] : 32'h0;
    assign inst       = d_valid ? r_mem[r_rp][31:0]  : 32'h0;
    assign count      = r_count;
    assign bubble_cnt = r_bubble;

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wp] <= {f_pc4, f_ins};
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + ONE;
            else if (w_pop && !w_push) r_count <= r_count - ONE;
        end
    end

    // Empty-queue decode bubbles; survives flush, saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_bubble <= '0;
        else if (wpcir && w_empty && !flush && (r_bubble != 16'hFFFF))
            r_bubble <= r_bubble + 16'd1;
    end

endmodule

// File: tb/tb_pipeifq.sv
// tb_pipeifq: randomized and directed bench for pipeifq against a queue model.
module tb_pipeifq;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          f_valid = 1'b0;
    logic [31:0]   f_pc4 = '0;
    logic [31:0]   f_ins = '0;
    logic          f_ready;
    logic          wpcir = 1'b0;
    logic          flush = 1'b0;
    logic          d_valid;
    logic [31:0]   dpc4;
    logic [31:0]   inst;
    logic [AW:0]   count;
    logic [15:0]   bubble_cnt;

    pipeifq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc4(f_pc4),
        .f_ins(f_ins), .f_ready(f_ready), .wpcir(wpcir), .flush(flush),
        .d_valid(d_valid), .dpc4(dpc4), .inst(inst), .count(count),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain FIFO of {pc4, ins} plus a bubble counter.
    logic [63:0] mq[$];
    int unsigned mbub = 0;

    // Expected output bundle {d_valid, f_ready, count, dpc4, inst, bubble_cnt}.
    function automatic logic [84:0] exp_vec();
        logic [31:0] p;
        logic [31:0] w;
        p = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        w = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
        return {mq.size() != 0, mq.size() != DEPTH, 3'(mq.size()), p, w, 16'(mbub)};
    endfunction

    function automatic logic [84:0] dut_vec();
        return {d_valid, f_ready, count, dpc4, inst, bubble_cnt};
    endfunction

    // Drive one cycle, advance the model by the queue rules, settle after the edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic wp, input logic fl);
        int sz;
        f_valid = fv; f_pc4 = pc; f_ins = ins; wpcir = wp; flush = fl;
        sz = mq.size();
        if (wp && sz == 0 && !fl && mbub != 32'hFFFF) mbub++;
        if (fl) mq.delete();
        else begin
            if (wp && sz != 0) void'(mq.pop_front());
            if (fv && sz != DEPTH) mq.push_back({pc, ins});
        end
        @(posedge clock);
        #1;
        f_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete(); mbub = 0;
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_state got %h exp %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (bubble_cnt !== 16'd5 || d_valid !== 1'b0 || inst !== 32'h0 || f_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle bubble=%0d dv=%b inst=%h frdy=%b exp 5/0/0/1",
                               bubble_cnt, d_valid, inst, f_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins_t [3];
        int unsigned b0;
        ins_t[0] = 32'h20080001; ins_t[1] = 32'h20090002; ins_t[2] = 32'h200A0003;
        b0 = bubble_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'((i+1)*4), ins_t[i], 1'b1, 1'b0);
            n_tests++;
            if (inst !== ins_t[i] || dpc4 !== 32'((i+1)*4) || count > 1 || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stream_%0d inst=%h pc4=%h cnt=%0d exp %h/%0d cnt<=1",
                                   i, inst, dpc4, count, ins_t[i], (i+1)*4);
            end
        end
        n_tests++;
        if (bubble_cnt !== 16'(b0 + 1)) begin
            n_fail++; $display("FAIL stream_bubble got %0d exp %0d", bubble_cnt, b0 + 1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i*4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        n_tests++;
        if (f_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++; $display("FAIL fill_full frdy=%b cnt=%0d exp 0/4", f_ready, count);
        end
        step(1'b1, 32'h110, 32'hA000_0004, 1'b0, 1'b0);
        n_tests++;
        if (count !== 3'd4 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL fill_refused cnt=%0d got %h exp %h", count, dut_vec(), exp_vec());
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (count !== 3'd3 || f_ready !== 1'b1 || inst !== 32'hA000_0001 || dpc4 !== 32'h104) begin
            n_fail++; $display("FAIL fill_pop cnt=%0d frdy=%b inst=%h pc4=%h exp 3/1/a0000001/104",
                               count, f_ready, inst, dpc4);
        end
        while (mq.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int nsent = 0;
        int cyc = 0;
        logic wp = 1'b1;
        while ((nsent < 10 || mq.size() != 0) && cyc < 200) begin
            if (wp && d_valid) got.push_back(inst);
            if (nsent < 10 && mq.size() != DEPTH) begin
                sent.push_back(32'hC000_0000 + 32'(nsent));
                step(1'b1, 32'(nsent*4), 32'hC000_0000 + 32'(nsent), wp, 1'b0);
                nsent++;
            end else step(1'b0, 32'h0, 32'h0, wp, 1'b0);
            wp = ~wp; cyc++;
        end
        n_tests++;
        if (cyc >= 200 || got.size() != 10 || got != sent) begin
            n_fail++; $display("FAIL wrap_order got %0d words (cyc %0d) exp 10 in push order",
                               got.size(), cyc);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i*4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h300, 32'hDEAD_BEEF, 1'b1, 1'b1);
        n_tests++;
        if (count !== 3'd0 || d_valid !== 1'b0 || f_ready !== 1'b1 || inst !== 32'h0) begin
            n_fail++; $display("FAIL flush_clear cnt=%0d dv=%b frdy=%b inst=%h exp 0/0/1/0",
                               count, d_valid, f_ready, inst);
        end
        step(1'b1, 32'h400, 32'h1234_5678, 1'b0, 1'b0);
        n_tests++;
        if (count !== 3'd1 || inst !== 32'h1234_5678 || dpc4 !== 32'h400) begin
            n_fail++; $display("FAIL flush_refill cnt=%0d inst=%h pc4=%h exp 1/12345678/400",
                               count, inst, dpc4);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
            if (dut_vec() !== exp_vec()) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cyc%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL random_total %0d mismatching cycles, exp 0", bad);
        end
    endtask

    task automatic test_saturation();
        while (mq.size() != 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        wpcir = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            if (mbub != 32'hFFFF) mbub++;
            @(posedge clock);
        end
        #1;
        n_tests++;
        if (bubble_cnt !== 16'hFFFF || 32'(bubble_cnt) !== mbub) begin
            n_fail++; $display("FAIL saturate got %h exp ffff", bubble_cnt);
        end
        step(1'b1, 32'h500, 32'h0000_0501, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h0000_0502, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bubble_cnt !== 16'h0 || count !== 3'd0 || d_valid !== 1'b0 || f_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset bubble=%h cnt=%0d dv=%b frdy=%b exp 0/0/0/1",
                               bubble_cnt, count, d_valid, f_ready);
        end
        #1 reset = 1'b0;
        mq.delete(); mbub = 0;
        step(1'b1, 32'h600, 32'h0000_0601, 1'b0, 1'b0);
        n_tests++;
        if (inst !== 32'h0000_0601 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset_push got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_wrap();
        test_flush();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeifq.md
# pipeifq

Instruction prefetch queue between the instruction-fetch stage and the decode stage of the five-stage MIPS32 pipeline. It buffers up to DEPTH fetched (pc4, instruction) pairs so that fetch keeps running while decode is frozen by a load-use stall. The queue presents the oldest entry to decode and discards all contents on a branch/jump redirect. It also keeps a saturating count of decode bubbles caused by an empty queue.

## Interface

- DEPTH, 4, number of queue entries; power of two, ≥2
- AW, 2, pointer width, log2(DEPTH)
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- f_valid  in  1  fetch presents a word this cycle
- f_pc4  in  32  PC+4 of the fetched word
- f_ins  in  32  fetched instruction word
- f_ready  out  1  queue can accept a word (= not full)
- wpcir  in  1  decode advance enable; 1 = decode consumes head, 0 = decode frozen
- flush  in  1  redirect (pcsource ≠ 00); discard every entry
- d_valid  out  1  head entry present
- dpc4  out  32  PC+4 of head entry; 0 when empty
- inst  out  32  head instruction; 32'h00000000 (nop) when empty
- count  out  AW+1  number of valid entries, 0..DEPTH
- bubble_cnt  out  16  saturating count of empty-queue decode cycles

## Operation

- Storage: DEPTH × 64-bit circular buffer, write pointer wp, read pointer rp (AW bits each, natural wrap DEPTH-1 → 0), occupancy count.
- push = f_valid & f_ready & ~flush; writes {f_pc4, f_ins} at wp, wp+1.
- pop = d_valid & wpcir & ~flush; rp+1.
- f_ready = (count ≠ DEPTH); combinational from count only. A push is refused when full, even if a pop occurs in the same cycle.
- Count update: push&~pop → +1; pop&~push → −1; both → unchanged; neither → unchanged.
- Simultaneous push and pop on an empty queue cannot occur, because d_valid=0 blocks the pop. The pushed word appears at the head next cycle.
- flush: wp←0, rp←0, count←0 at the next edge. Any same-cycle push and pop are ignored. flush has priority over everything.
- Head outputs are combinational from storage[rp], gated by d_valid = (count ≠ 0). When empty: dpc4=0, inst=0.
- bubble_cnt increments when wpcir=1 & count=0 & ~flush. It saturates at 16'hFFFF and never wraps. It is not cleared by flush.
- Storage contents need no reset; pointers, count and bubble_cnt do.

## Timing

- Reset, asynchronous and immediate: wp=rp=0, count=0, bubble_cnt=0. As a result f_ready=1, d_valid=0, dpc4=0, inst=0.
- Reset asserted mid-operation: all entries are lost at once. The first push after reset deassertion is taken on the next rising edge.
- Fetch-to-decode latency: 1 cycle. A word pushed at edge N is on inst/dpc4 after edge N.
- Full: f_ready=0 in the cycle count=DEPTH. A pop at edge N raises f_ready after edge N, so the earliest refill is at edge N+1.
- Empty: d_valid=0 in the cycle count=0. Decode sees a nop and bubble_cnt counts if wpcir=1.
- flush at edge N: after N, the queue is empty and f_ready=1. A word fetched from the target PC can be pushed at edge N+1.
- Ordering is strict FIFO across pointer wrap-around.

## Test plan

- Reset then idle: assert reset for 2 cycles, release, keep f_valid=0 and wpcir=1 for 5 cycles → d_valid=0, inst=0, f_ready=1, bubble_cnt=5.
- Stream through: push pc4=4,8,12 with instructions 0x20080001, 0x20090002, 0x200A0003 on consecutive cycles with wpcir=1 → inst shows them in order one cycle after each push, count stays ≤1, bubble_cnt unchanged after the first word arrives.
- Fill under stall: wpcir=0, push 5 words → first 4 accepted, f_ready=0 and count=4 during the 5th attempt. Then wpcir=1 for one cycle → count=3, f_ready=1, head = second word.
- Wrap-around: push/pop 10 words with wpcir toggling 1,0 each cycle → decode order equals push order across pointer wrap, no duplicates or drops.
- Flush priority: count=3 with f_valid=1 and wpcir=1, assert flush for one cycle → count=0, d_valid=0, neither the pushed word nor the head pop takes effect. A push next cycle appears as the head.
- Saturation and async reset: force 65 540 empty decode cycles → bubble_cnt=16'hFFFF. Then pulse reset between clock edges → bubble_cnt=0 and count=0 immediately, without waiting for an edge.
